// File: rtl/sprite_draw_scheduler_if.sv
// Draw-request bus between the sprite draw scheduler and the sprite blitter.
// The master presents one request at a time over a valid/ready handshake.
interface sprite_draw_scheduler_if #(
  parameter int unsigned ADDR_DEPTH     = 8,
  parameter int unsigned POSITION_DEPTH = 10
);
  logic                      draw_valid;
  logic                      draw_ready;
  logic                      draw_player;
  logic [ADDR_DEPTH-1:0]     draw_base;
  logic [POSITION_DEPTH-1:0] draw_x;
  logic                      draw_mirror;

  modport master (
    output draw_valid,
    output draw_player,
    output draw_base,
    output draw_x,
    output draw_mirror,
    input  draw_ready
  );

  modport slave (
    input  draw_valid,
    input  draw_player,
    input  draw_base,
    input  draw_x,
    input  draw_mirror,
    output draw_ready
  );
endinterface

// File: rtl/sprite_draw_scheduler.sv
// Per-frame scheduler: on each frame tick, snapshots settled game-logic state and issues
// P1 then P2 sprite draw requests to the blitter; ticks arriving while busy are counted.
module sprite_draw_scheduler #(
  parameter int unsigned STATE_DEPTH        = 4,
  parameter int unsigned POSITION_DEPTH     = 10,
  parameter int unsigned SPRITE_INDEX_DEPTH = 4,
  parameter int unsigned FRAMES_PER_STATE   = 8,
  parameter int unsigned SPRITE_W           = 64,
  parameter int unsigned ADDR_DEPTH         = 8,
  parameter int unsigned DROP_DEPTH         = 8
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          frame_clk,
  input  logic                          done_gen,
  input  logic [STATE_DEPTH-1:0]        p1_state,
  input  logic [STATE_DEPTH-1:0]        p2_state,
  input  logic [POSITION_DEPTH-1:0]     p1_position,
  input  logic [POSITION_DEPTH-1:0]     p2_position,
  input  logic [SPRITE_INDEX_DEPTH-1:0] p1_sprite,
  input  logic [SPRITE_INDEX_DEPTH-1:0] p2_sprite,
  sprite_draw_scheduler_if.master       draw,
  output logic                          frame_done,
  output logic                          overrun,
  output logic [DROP_DEPTH-1:0]         drop_count
);

  localparam logic [POSITION_DEPTH-1:0]     HalfW  = POSITION_DEPTH'(SPRITE_W / 2);
  localparam logic [SPRITE_INDEX_DEPTH-1:0] MaxIdx = SPRITE_INDEX_DEPTH'(FRAMES_PER_STATE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitGen,
    StSendP1,
    StSendP2,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic sync1_q, sync2_q, sync3_q, tick_q;
  logic capture;
  logic drop;
  logic overrun_q;
  logic [DROP_DEPTH-1:0] drop_count_q;

  logic [STATE_DEPTH-1:0]        p1_state_q, p2_state_q;
  logic [POSITION_DEPTH-1:0]     p1_pos_q, p2_pos_q;
  logic [SPRITE_INDEX_DEPTH-1:0] p1_sprite_q, p2_sprite_q;

  logic                          sending, send_p2;
  logic [STATE_DEPTH-1:0]        sel_state;
  logic [POSITION_DEPTH-1:0]     sel_pos;
  logic [SPRITE_INDEX_DEPTH-1:0] sel_sprite, idx;

  // Two-flop synchroniser, then a registered rising-edge detect.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      tick_q  <= sync2_q & ~sync3_q;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle:    if (tick_q) state_d = StWaitGen;
      StWaitGen: begin
        if (done_gen) begin
          capture = 1'b1;
          state_d = StSendP1;
        end
      end
      StSendP1:  if (draw.draw_ready) state_d = StSendP2;
      StSendP2:  if (draw.draw_ready) state_d = StDone;
      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      p1_state_q  <= '0;
      p2_state_q  <= '0;
      p1_pos_q    <= '0;
      p2_pos_q    <= '0;
      p1_sprite_q <= '0;
      p2_sprite_q <= '0;
    end else if (capture) begin
      p1_state_q  <= p1_state;
      p2_state_q  <= p2_state;
      p1_pos_q    <= p1_position;
      p2_pos_q    <= p2_position;
      p1_sprite_q <= p1_sprite;
      p2_sprite_q <= p2_sprite;
    end
  end

  assign drop = tick_q && (state_q != StIdle);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      overrun_q    <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overrun_q <= 1'b1;
      if (drop_count_q != '1) drop_count_q <= drop_count_q + 1'b1;
    end
  end

  assign overrun    = overrun_q;
  assign drop_count = drop_count_q;

  assign sending    = (state_q == StSendP1) || (state_q == StSendP2);
  assign send_p2    = (state_q == StSendP2);
  assign sel_state  = send_p2 ? p2_state_q  : p1_state_q;
  assign sel_pos    = send_p2 ? p2_pos_q    : p1_pos_q;
  assign sel_sprite = send_p2 ? p2_sprite_q : p1_sprite_q;

  // Fields are driven only while a request is live so idle outputs read as zero.
  always_comb begin
    idx              = sel_sprite;
    draw.draw_valid  = sending;
    draw.draw_player = send_p2;
    draw.draw_base   = '0;
    draw.draw_x      = '0;
    draw.draw_mirror = 1'b0;
    if (32'(sel_sprite) > FRAMES_PER_STATE - 1) idx = MaxIdx;
    if (sending) begin
      // Modular arithmetic at ADDR_DEPTH equals truncating the full-width sum.
      draw.draw_base = ADDR_DEPTH'(sel_state) * ADDR_DEPTH'(FRAMES_PER_STATE) + ADDR_DEPTH'(idx);
      draw.draw_x    = (sel_pos >= HalfW) ? (sel_pos - HalfW) : '0;
      // Equal positions: P1 faces right, P2 faces left.
      draw.draw_mirror = send_p2 ? (p2_pos_q >= p1_pos_q) : (p1_pos_q > p2_pos_q);
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler: latency, field arithmetic, backpressure,
// dropped-tick accounting and mid-handshake reset, against hand-computed values.
module tb_sprite_draw_scheduler;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       frame_clk;
  logic       done_gen;
  logic [3:0] p1_state, p2_state;
  logic [9:0] p1_position, p2_position;
  logic [3:0] p1_sprite, p2_sprite;
  logic       frame_done;
  logic       overrun;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;

  sprite_draw_scheduler_if #(.ADDR_DEPTH(8), .POSITION_DEPTH(10)) draw_bus ();

  sprite_draw_scheduler dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .frame_clk   (frame_clk),
    .done_gen    (done_gen),
    .p1_state    (p1_state),
    .p2_state    (p2_state),
    .p1_position (p1_position),
    .p2_position (p2_position),
    .p1_sprite   (p1_sprite),
    .p2_sprite   (p2_sprite),
    .draw        (draw_bus),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .drop_count  (drop_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_players(input logic [3:0] s1, input logic [3:0] sp1, input logic [9:0] x1,
                             input logic [3:0] s2, input logic [3:0] sp2, input logic [9:0] x2);
    p1_state = s1; p1_sprite = sp1; p1_position = x1;
    p2_state = s2; p2_sprite = sp2; p2_position = x2;
  endtask

  // Raise frame_clk for three cycles; tick lands on the third edge.
  task automatic pulse_frame();
    frame_clk = 1'b1;
    repeat (3) @(negedge sys_clk);
    frame_clk = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!draw_bus.draw_valid && n < max_cycles) begin
      @(negedge sys_clk);
      n++;
    end
    check("valid_wait", draw_bus.draw_valid, 1);
  endtask

  task automatic check_req(input string tag, input logic player, input logic [7:0] base,
                           input logic [9:0] x, input logic mirror);
    check({tag, "_valid"},  draw_bus.draw_valid, 1);
    check({tag, "_player"}, draw_bus.draw_player, player);
    check({tag, "_base"},   draw_bus.draw_base, base);
    check({tag, "_x"},      draw_bus.draw_x, x);
    check({tag, "_mirror"}, draw_bus.draw_mirror, mirror);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; frame_clk = 1'b0; done_gen = 1'b0; draw_bus.draw_ready = 1'b0;
    set_players(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge sys_clk);
    check("rst_valid", draw_bus.draw_valid, 0);
    check("rst_player", draw_bus.draw_player, 0);
    check("rst_base", draw_bus.draw_base, 0);
    check("rst_x", draw_bus.draw_x, 0);
    check("rst_mirror", draw_bus.draw_mirror, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_drop", drop_count, 0);
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("idle_valid", draw_bus.draw_valid, 0);

    // Frame 1: latency and nominal fields.
    set_players(3, 5, 100, 1, 2, 400);
    done_gen = 1'b1; draw_bus.draw_ready = 1'b1;
    frame_clk = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("lat_edge4", draw_bus.draw_valid, 0);
    @(negedge sys_clk);
    check_req("f1_p1", 0, 29, 68, 0);
    frame_clk = 1'b0;
    @(negedge sys_clk);
    check_req("f1_p2", 1, 10, 368, 1);
    @(negedge sys_clk);
    check("f1_done_valid", draw_bus.draw_valid, 0);
    check("f1_frame_done", frame_done, 1);
    @(negedge sys_clk);
    check("f1_frame_done_end", frame_done, 0);
    check("f1_overrun", overrun, 0);

    // Clamped sprite index, saturated x, equal positions.
    set_players(3, 12, 20, 0, 0, 20);
    pulse_frame();
    wait_valid(10);
    check_req("bnd_p1", 0, 31, 0, 0);
    @(negedge sys_clk);
    check_req("bnd_p2", 1, 0, 0, 1);
    @(negedge sys_clk);
    check("bnd_frame_done", frame_done, 1);

    // Backpressure with changing inputs and ticks while stalled.
    draw_bus.draw_ready = 1'b0;
    set_players(2, 1, 500, 4, 3, 200);
    repeat (3) @(negedge sys_clk);
    pulse_frame();
    wait_valid(10);
    check_req("bp_p1", 0, 17, 468, 1);
    set_players(9, 7, 5, 6, 6, 900);
    done_gen = 1'b0;
    repeat (10) @(negedge sys_clk);
    check_req("bp_hold", 0, 17, 468, 1);
    for (int i = 0; i < 3; i++) begin
      pulse_frame();
      repeat (3) @(negedge sys_clk);
    end
    check("bp_overrun", overrun, 1);
    check("bp_drop3", drop_count, 3);
    check_req("bp_hold2", 0, 17, 468, 1);
    draw_bus.draw_ready = 1'b1;
    @(negedge sys_clk);
    check_req("bp_p2", 1, 35, 168, 0);
    @(negedge sys_clk);
    check("bp_frame_done", frame_done, 1);
    check("bp_done_valid", draw_bus.draw_valid, 0);

    // Stall in WAIT_GEN and saturate the drop counter.
    pulse_frame();
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 300; i++) begin
      pulse_frame();
      repeat (3) @(negedge sys_clk);
      if (i == 250) check("drop_254", drop_count, 254);
    end
    check("drop_sat", drop_count, 255);
    check("wait_gen_valid", draw_bus.draw_valid, 0);
    done_gen = 1'b1;
    wait_valid(5);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("sat_frame_done", frame_done, 1);

    // Reset while stalled in SEND_P2.
    draw_bus.draw_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    pulse_frame();
    wait_valid(10);
    draw_bus.draw_ready = 1'b1;
    @(negedge sys_clk);
    draw_bus.draw_ready = 1'b0;
    @(negedge sys_clk);
    check("p2_stall_player", draw_bus.draw_player, 1);
    check("p2_stall_valid", draw_bus.draw_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", draw_bus.draw_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_drop", drop_count, 0);
    @(negedge sys_clk);
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("post_rst_valid", draw_bus.draw_valid, 0);
    set_players(5, 0, 40, 2, 9, 300);
    draw_bus.draw_ready = 1'b1;
    pulse_frame();
    wait_valid(10);
    check_req("post_p1", 0, 40, 8, 0);
    @(negedge sys_clk);
    check_req("post_p2", 1, 23, 268, 1);
    @(negedge sys_clk);
    check("post_frame_done", frame_done, 1);
    check("post_overrun", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
- Consumer end of the game-logic output bus.
- Once per frame tick it waits for game logic to finish generating (done_gen), then snapshots both players' state, position and sprite index.
- It then issues two draw requests, P1 then P2, to the sprite blitter over a valid/ready handshake. Each request carries a sprite-ROM base address, a screen X and a mirror flag.
- Decouples the renderer from live game-logic wires so a frame is never drawn from half-updated values.

Parameters:
- STATE_DEPTH, 4, width of player state.
- POSITION_DEPTH, 10, width of player X position.
- SPRITE_INDEX_DEPTH, 4, width of per-state animation frame index.
- FRAMES_PER_STATE, 8, animation frames stored per state in sprite ROM.
- SPRITE_W, 64, sprite width in pixels; position is the sprite centre.
- ADDR_DEPTH, 8, width of sprite-ROM base address.
- DROP_DEPTH, 8, width of dropped-frame counter.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous active-low reset.
- frame_clk  in  1  frame tick level, asynchronous to sys_clk; synchronised internally.
- done_gen  in  1  game logic has settled for the current frame.
- p1_state, p2_state  in  STATE_DEPTH  player states.
- p1_position, p2_position  in  POSITION_DEPTH  player X centres.
- p1_sprite, p2_sprite  in  SPRITE_INDEX_DEPTH  animation frame indices.
- draw_valid  out  1  draw request valid.
- draw_ready  in  1  blitter accepts request.
- draw_player  out  1  0 = P1, 1 = P2.
- draw_base  out  ADDR_DEPTH  sprite-ROM base address.
- draw_x  out  POSITION_DEPTH  left edge of sprite.
- draw_mirror  out  1  draw horizontally flipped.
- frame_done  out  1  one-cycle pulse after both requests are accepted.
- overrun  out  1  sticky; a tick arrived while busy.
- drop_count  out  DROP_DEPTH  saturating count of dropped ticks.

Behaviour:

Reset:
- rst low asynchronously forces all outputs to 0, FSM to IDLE, synchroniser flops to 0 and snapshot registers to 0.
- Reset mid-handshake aborts the request; draw_valid drops immediately.

Tick:
- frame_clk passes through a 2-flop synchroniser, then a rising-edge detect.
- tick is a 1-cycle pulse 3 sys_clk edges after frame_clk rises.

FSM states: IDLE, WAIT_GEN, SEND_P1, SEND_P2, DONE.
- IDLE: on tick, go to WAIT_GEN.
- WAIT_GEN: in the cycle done_gen==1, capture all six inputs into the snapshot and go to SEND_P1. With done_gen already high on entry, draw_valid rises exactly 1 cycle after the WAIT_GEN entry cycle.
- SEND_P1: draw_valid=1 and draw_player=0, fields from the P1 snapshot. On draw_valid&draw_ready, go to SEND_P2; valid stays high, so back-to-back transfers are allowed.
- SEND_P2: draw_valid=1 and draw_player=1. On handshake, go to DONE.
- DONE: draw_valid=0 and frame_done=1 for exactly one cycle, then IDLE.

Handshake rules:
- Once draw_valid is high, all draw_* fields stay stable until accepted.
- draw_valid never drops without a handshake, except on reset.
- draw_ready is ignored outside the SEND states.

Dropped ticks:
- A tick in any state other than IDLE (including the cycle DONE→IDLE) is dropped.
- On a dropped tick, overrun is set and drop_count increments, saturating at all-ones.
- Both are cleared only by reset.

Field arithmetic (from the snapshot):
- idx = min(sprite, FRAMES_PER_STATE-1).
- draw_base = state*FRAMES_PER_STATE + idx, computed at full width, then truncated to ADDR_DEPTH.
- draw_x = position - SPRITE_W/2, saturating at 0.
- Mirror, P1: draw_mirror = (p1_pos > p2_pos).
- Mirror, P2: draw_mirror = (p2_pos >= p1_pos), so with equal positions P1 faces right and P2 faces left.

Boundary conditions:
- done_gen low indefinitely: the FSM waits in WAIT_GEN; further ticks count as drops.
- done_gen toggling after capture has no effect on the current frame.
- Input changes after capture do not affect the current frame.

Test Plan:
- Reset then idle → all outputs 0; a frame_clk rise with done_gen=1 gives draw_valid high 4 sys_clk cycles after the rise (tick at edge 3, WAIT_GEN entry at edge 4, valid at edge 5).
- Values: p1_state=3, p1_sprite=5, p1_pos=100, p2_state=1, p2_sprite=2, p2_pos=400, draw_ready=1 → P1 request base=29, x=68, mirror=0; P2 request base=10, x=368, mirror=1; frame_done pulses 1 cycle.
- Boundary fields: p1_sprite=12, p1_state=3, p1_pos=20, p2_pos=20 → P1 base=31, x=0, mirror=0; P2 mirror=1.
- Backpressure: draw_ready held 0 for 10 cycles during SEND_P1 while the inputs change → draw_* fields unchanged and valid held; P2 is issued only after ready.
- Overrun: three ticks while stalled in SEND_P1 → overrun=1, drop_count=3; 300 drops → drop_count=255.
- Assert rst low during SEND_P2 → draw_valid=0 immediately; after release the FSM is in IDLE and the next tick produces a fresh P1 request.
